// File: rtl/spi_reg_hub_pkg.sv
// Shared types and constants for the SPI register hub.
package spi_hub_pkg;

    typedef enum logic [2:0] {IDLE, CMD, REG, STAT, MEM, IGN} state_t;

    localparam int CMD_W        = 8;
    localparam int CMD_W_BIT    = 7;
    localparam int CMD_ADDR_MSB = 6;
    localparam int STATUS_W     = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_reg_hub_if.sv
// SPI pins plus config/status/memory buses of the hub; no backpressure, all strobes are 1-clk pulses.
interface spi_reg_hub_if #(
    parameter int NREG  = 4,
    parameter int REG_W = 32,
    parameter int AW    = 12,
    parameter int MW    = 16
);
    logic                  ncs_spi;
    logic                  sck_spi;
    logic                  mosi_spi;
    logic                  miso_spi;
    logic [NREG*REG_W-1:0] cfg_q;
    logic [NREG-1:0]       cfg_wr_stb;
    logic [15:0]           status_in;
    logic [AW-1:0]         mem_addr;
    logic                  mem_rd_stb;
    logic [MW-1:0]         mem_data;

    modport slave (
        input  ncs_spi, sck_spi, mosi_spi, status_in, mem_data,
        output miso_spi, cfg_q, cfg_wr_stb, mem_addr, mem_rd_stb
    );

    modport master (
        output ncs_spi, sck_spi, mosi_spi, status_in, mem_data,
        input  miso_spi, cfg_q, cfg_wr_stb, mem_addr, mem_rd_stb
    );
endinterface

// File: rtl/spi_reg_hub_edge_sync.sv
// Two-flop synchronisers for the SPI pins plus registered edge pulses.
// Pin-to-event latency is 3 clk; mosi and ncs level are delayed to line up with the events.
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_ncs,
    input  logic i_sck,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ncs_fall,
    output logic o_ncs_rise,
    output logic o_ncs,
    output logic o_mosi
);
    logic [2:0] r_sck;
    logic [2:0] r_ncs;
    logic [1:0] r_mosi;
    logic       r_sck_rise, r_sck_fall, r_ncs_fall, r_ncs_rise, r_ncs_lvl, r_mosi_q;

    // ncs chain resets low so a frame already running at reset never shows a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck      <= '0;
            r_ncs      <= '0;
            r_mosi     <= '0;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_ncs_fall <= 1'b0;
            r_ncs_rise <= 1'b0;
            r_ncs_lvl  <= 1'b0;
            r_mosi_q   <= 1'b0;
        end else begin
            r_sck      <= {r_sck[1:0], i_sck};
            r_ncs      <= {r_ncs[1:0], i_ncs};
            r_mosi     <= {r_mosi[0], i_mosi};
            r_sck_rise <= r_sck[1] & ~r_sck[2];
            r_sck_fall <= ~r_sck[1] & r_sck[2];
            r_ncs_fall <= ~r_ncs[1] & r_ncs[2];
            r_ncs_rise <= r_ncs[1] & ~r_ncs[2];
            r_ncs_lvl  <= r_ncs[1];
            r_mosi_q   <= r_mosi[1];
        end
    end

    assign o_sck_rise = r_sck_rise;
    assign o_sck_fall = r_sck_fall;
    assign o_ncs_fall = r_ncs_fall;
    assign o_ncs_rise = r_ncs_rise;
    assign o_ncs      = r_ncs_lvl;
    assign o_mosi     = r_mosi_q;
endmodule

// File: rtl/spi_reg_hub.sv
// SPI mode-0 slave: config register bank with auto-increment bursts, status word, memory read stream.
// Events lag the pins by 3 clk; no backpressure, sck must stay at or below clk/8.
module spi_reg_hub
    import spi_hub_pkg::*;
#(
    parameter int               NREG      = 4,
    parameter int               REG_W     = 32,
    parameter int               AW        = 12,
    parameter int               MW        = 16,
    parameter logic [7:0]       DEV_ID    = 8'h91,
    parameter logic [REG_W-1:0] CFG_RESET = '0
) (
    input  logic clk,
    input  logic rst,
    spi_reg_hub_if.slave bus
);
    localparam int TXW = max3(REG_W, MW, STATUS_W);
    localparam int CW  = $clog2(TXW + 1);
    localparam int PW  = (NREG > 1) ? $clog2(NREG) : 1;

    logic w_sck_rise, w_sck_fall, w_ncs_fall, w_ncs_rise, w_ncs, w_mosi;

    spi_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_ncs      (bus.ncs_spi),
        .i_sck      (bus.sck_spi),
        .i_mosi     (bus.mosi_spi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_ncs_fall (w_ncs_fall),
        .o_ncs_rise (w_ncs_rise),
        .o_ncs      (w_ncs),
        .o_mosi     (w_mosi)
    );

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_bitcnt, w_len_m1;
    logic [REG_W-2:0] r_rx;
    logic [REG_W-1:0] w_rx_nxt;
    logic [TXW-1:0]   r_tx;
    logic [PW-1:0]    r_ptr, w_ptr_inc;
    logic             r_wr, r_miso, r_mem_stb;
    logic [REG_W-1:0] r_cfg [NREG];
    logic [NREG-1:0]  r_stb;
    logic [AW-1:0]    r_mem_addr;
    logic [6:0]       w_addr;
    logic             w_word_done, w_addr_is_reg, w_addr_is_stat, w_ptr_last;

    assign w_rx_nxt       = {r_rx, w_mosi};
    assign w_addr         = w_rx_nxt[CMD_ADDR_MSB:0];
    assign w_addr_is_reg  = int'(w_addr) < NREG;
    assign w_addr_is_stat = int'(w_addr) == NREG;
    assign w_ptr_inc      = r_ptr + 1'b1;
    assign w_ptr_last     = (r_ptr == PW'(NREG - 1));
    assign w_word_done    = w_sck_rise && (r_bitcnt == w_len_m1);

    always_comb begin
        w_len_m1 = CW'(TXW - 1);
        case (r_state)
            CMD:     w_len_m1 = CW'(CMD_W - 1);
            REG:     w_len_m1 = CW'(REG_W - 1);
            STAT:    w_len_m1 = CW'(STATUS_W - 1);
            MEM:     w_len_m1 = CW'(MW - 1);
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ncs) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_ncs_fall) w_state_nxt = CMD;
                CMD: if (w_word_done) begin
                    if (w_addr_is_reg)       w_state_nxt = REG;
                    else if (w_addr_is_stat) w_state_nxt = STAT;
                    else                     w_state_nxt = IGN;
                end
                REG:  if (w_word_done && w_ptr_last) w_state_nxt = IGN;
                STAT: if (w_word_done) w_state_nxt = MEM;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Transmit data is held MSB-aligned in r_tx whatever the word width
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt   <= '0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_ptr      <= '0;
            r_wr       <= 1'b0;
            r_miso     <= 1'b0;
            r_stb      <= '0;
            r_mem_stb  <= 1'b0;
            r_mem_addr <= '0;
            for (int k = 0; k < NREG; k++) r_cfg[k] <= CFG_RESET;
        end else begin
            r_stb     <= '0;
            r_mem_stb <= 1'b0;
            if (w_ncs_rise) r_wr <= 1'b0;
            if (w_ncs) begin
                r_bitcnt <= '0;
                r_miso   <= 1'b0;
            end else begin
                if (r_state == IDLE && w_ncs_fall) begin
                    r_bitcnt <= '0;
                    r_tx     <= TXW'(DEV_ID) << (TXW - 7);
                    r_miso   <= DEV_ID[7];
                end
                if (w_sck_rise && r_state != IDLE && r_state != IGN) begin
                    r_rx     <= w_rx_nxt[REG_W-2:0];
                    r_bitcnt <= w_word_done ? '0 : r_bitcnt + 1'b1;
                end
                if (w_word_done) begin
                    case (r_state)
                        CMD: begin
                            r_wr <= w_rx_nxt[CMD_W_BIT];
                            if (w_addr_is_reg) begin
                                r_ptr <= PW'(w_addr);
                                r_tx  <= TXW'(r_cfg[PW'(w_addr)]) << (TXW - REG_W);
                            end else if (w_addr_is_stat) begin
                                r_tx       <= TXW'(bus.status_in) << (TXW - STATUS_W);
                                r_mem_addr <= '0;
                                r_mem_stb  <= 1'b1;
                            end else begin
                                r_tx <= '0;
                            end
                        end
                        REG: begin
                            if (r_wr) begin
                                r_cfg[r_ptr] <= w_rx_nxt;
                                r_stb[r_ptr] <= 1'b1;
                            end
                            if (w_ptr_last) begin
                                r_tx <= '0;
                            end else begin
                                r_ptr <= w_ptr_inc;
                                r_tx  <= TXW'(r_cfg[w_ptr_inc]) << (TXW - REG_W);
                            end
                        end
                        STAT, MEM: begin
                            r_tx       <= TXW'(bus.mem_data) << (TXW - MW);
                            r_mem_addr <= r_mem_addr + 1'b1;
                            r_mem_stb  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (w_sck_fall) begin
                    r_miso <= (r_state == IDLE || r_state == IGN) ? 1'b0 : r_tx[TXW-1];
                    r_tx   <= r_tx << 1;
                end
            end
        end
    end

    always_comb begin
        bus.cfg_q = '0;
        for (int k = 0; k < NREG; k++) bus.cfg_q[k*REG_W +: REG_W] = r_cfg[k];
    end

    assign bus.cfg_wr_stb = r_stb;
    assign bus.miso_spi   = r_miso;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_rd_stb = r_mem_stb;
endmodule

// File: tb/tb_spi_reg_hub.sv
// Directed-sequence bench for spi_reg_hub with random data checked against a register/memory model.
module tb_spi_reg_hub;
    localparam int NREG = 4, REG_W = 32, AW = 4, MW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_reg_hub_if #(.NREG(NREG), .REG_W(REG_W), .AW(AW), .MW(MW)) bus ();

    spi_reg_hub #(.NREG(NREG), .REG_W(REG_W), .AW(AW), .MW(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Capture buffer contents: word n holds n ^ 0xA5A5, presented 1 clk after the address
    always @(posedge clk) bus.mem_data <= 16'hA5A5 ^ 16'(bus.mem_addr);

    int n_checks = 0;
    int n_err    = 0;
    int stb_cnt [NREG];
    int exp_stb [NREG];
    int mem_stb_cnt = 0;
    logic [31:0] m_cfg [NREG];

    initial for (int j = 0; j < NREG; j++) stb_cnt[j] = 0;

    always @(negedge clk) begin
        for (int j = 0; j < NREG; j++) if (bus.cfg_wr_stb[j]) stb_cnt[j]++;
        if (bus.mem_rd_stb) mem_stb_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_cfg();
        return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_cfg"}, bus.cfg_q, model_cfg());
        for (int j = 0; j < NREG; j++)
            check($sformatf("%s_stb%0d", tag, j), 128'(stb_cnt[j]), 128'(exp_stb[j]));
    endtask

    task automatic cs_low();
        bus.ncs_spi = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #40;
        bus.ncs_spi = 1'b1;
        #100;
    endtask

    // Mode 0 master: drive MOSI, sample MISO just before each rising sck
    task automatic xfer(input int n, input logic [63:0] d, output logic [63:0] q);
        q = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.mosi_spi = d[i];
            #80;
            q[i] = bus.miso_spi;
            bus.sck_spi = 1'b1;
            #80;
            bus.sck_spi = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] q;
        logic [31:0] v, a, b, c;
        logic [15:0] s;
        int k;

        bus.ncs_spi   = 1'b1;
        bus.sck_spi   = 1'b0;
        bus.mosi_spi  = 1'b0;
        bus.status_in = '0;
        for (int j = 0; j < NREG; j++) begin
            m_cfg[j]   = '0;
            exp_stb[j] = 0;
        end
        #3;
        #50 rst = 1'b0;
        #100;

        check("rst_miso", bus.miso_spi, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check_regs("rst");

        // Plain read of reg 0
        cs_low();
        xfer(8, 64'h00, q);
        check("t1_devid", q[7:0], 8'h91);
        xfer(32, 64'(32'($urandom)), q);
        check("t1_reg0", q[31:0], m_cfg[0]);
        cs_high();
        check_regs("t1");

        // Single writes with readback; the read during a write returns old content
        for (int it = 0; it < 3; it++) begin
            k = (it == 0) ? 1 : int'($urandom_range(0, NREG - 1));
            v = (it == 0) ? 32'hDEADBEEF : 32'($urandom);
            cs_low();
            xfer(8, 64'(8'h80 | 8'(k)), q);
            check("t2_devid", q[7:0], 8'h91);
            xfer(32, 64'(v), q);
            check("t2_old", q[31:0], m_cfg[k]);
            cs_high();
            m_cfg[k] = v;
            exp_stb[k]++;
            check_regs("t2");
            cs_low();
            xfer(8, 64'(8'(k)), q);
            xfer(32, 64'(32'($urandom)), q);
            check("t2_readback", q[31:0], v);
            cs_high();
            check_regs("t2_rd");
        end

        // Burst write running off the end of the bank
        a = $urandom; b = $urandom; c = $urandom;
        cs_low();
        xfer(8, 64'h82, q);
        xfer(32, 64'(a), q);
        check("t3_old2", q[31:0], m_cfg[2]);
        xfer(32, 64'(b), q);
        check("t3_old3", q[31:0], m_cfg[3]);
        xfer(32, 64'(c), q);
        check("t3_ign_miso", q[31:0], 0);
        cs_high();
        m_cfg[2] = a; m_cfg[3] = b;
        exp_stb[2]++; exp_stb[3]++;
        check_regs("t3");

        // Status word then memory stream, long enough to wrap the address
        s = 16'($urandom);
        bus.status_in = s;
        mem_stb_cnt = 0;
        cs_low();
        xfer(8, 64'({1'($urandom), 7'd4}), q);
        check("t4_devid", q[7:0], 8'h91);
        xfer(16, 64'(16'($urandom)), q);
        check("t4_status", q[15:0], s);
        for (int w = 0; w < 20; w++) begin
            xfer(16, 64'(16'($urandom)), q);
            check($sformatf("t4_mem%0d", w), q[15:0], 16'hA5A5 ^ 16'(w % (1 << AW)));
        end
        check("t4_mem_addr", bus.mem_addr, 21 % (1 << AW));
        check("t4_mem_stb", 128'(mem_stb_cnt), 22);
        cs_high();
        check_regs("t4");

        // Frame aborted mid-word leaves reg 0 alone
        cs_low();
        xfer(8, 64'h80, q);
        xfer(20, 64'($urandom), q);
        cs_high();
        check_regs("t5");
        cs_low();
        xfer(8, 64'h00, q);
        check("t5_devid", q[7:0], 8'h91);
        xfer(32, 64'h0, q);
        check("t5_reg0", q[31:0], m_cfg[0]);
        cs_high();

        // Reset in the middle of a write frame
        cs_low();
        xfer(8, 64'h81, q);
        xfer(10, 64'($urandom), q);
        rst = 1'b1;
        #30;
        rst = 1'b0;
        xfer(22, 64'($urandom), q);
        check("t6_miso_quiet", q[21:0], 0);
        cs_high();
        for (int j = 0; j < NREG; j++) m_cfg[j] = '0;
        check_regs("t6");
        v = $urandom;
        cs_low();
        xfer(8, 64'h81, q);
        check("t6_devid", q[7:0], 8'h91);
        xfer(32, 64'(v), q);
        check("t6_old", q[31:0], 0);
        cs_high();
        m_cfg[1] = v;
        exp_stb[1]++;
        check_regs("t6_after");
        cs_low();
        xfer(8, 64'h01, q);
        xfer(32, 64'h0, q);
        check("t6_readback", q[31:0], v);
        cs_high();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
